xmm_write_arbiter: RTL

Arbitrates the single XMM register file write port between three producers: the ALU conversion path (u32/i32/fp32 to Q15), memory load results and the FPU. It drives the XMM write-mux source select, write enable and write address in the cycle a producer is granted. Fixed priority with age-based promotion bounds the wait of every producer. A registered write-back record feeds the issue scoreboard.

---
 rtl/xmm_write_arbiter_if.sv | 37 +++
 rtl/xmm_write_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/xmm_write_arbiter_if.sv
// rtl/xmm_write_arbiter_if.sv - XMM write-port arbiter bundle: producer handshakes, write port, write-back record
// master = producers/observer side, slave = arbiter side.
interface xmm_write_arbiter_if #(
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [1:0]        alu_fmt;
  logic [ADDR_W-1:0] alu_rd;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic              mem_ready;
  logic              fpu_valid;
  logic [ADDR_W-1:0] fpu_rd;
  logic              fpu_ready;
  logic              xmm_stall;
  logic [2:0]        mux_src;
  logic              xmm_we;
  logic [ADDR_W-1:0] xmm_waddr;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [2:0]        wb_src;
  logic              fmt_err;
  logic [15:0]       wr_count;

  modport master (
    output alu_valid, alu_fmt, alu_rd, mem_valid, mem_rd, fpu_valid, fpu_rd, xmm_stall,
    input  alu_ready, mem_ready, fpu_ready, mux_src, xmm_we, xmm_waddr,
    input  wb_valid, wb_rd, wb_src, fmt_err, wr_count
  );

  modport slave (
    input  alu_valid, alu_fmt, alu_rd, mem_valid, mem_rd, fpu_valid, fpu_rd, xmm_stall,
    output alu_ready, mem_ready, fpu_ready, mux_src, xmm_we, xmm_waddr,
    output wb_valid, wb_rd, wb_src, fmt_err, wr_count
  );
endinterface

// File: rtl/xmm_write_arbiter.sv
// rtl/xmm_write_arbiter.sv - fixed-priority XMM write-port arbiter with age promotion and write-back record
// Base order mem > fpu > alu; a requester stalled MAX_WAIT cycles becomes urgent and beats non-urgent ones.
module xmm_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  xmm_write_arbiter_if.slave  bus
);

  localparam logic [3:0] L_MAX_WAIT = 4'(MAX_WAIT);

  localparam logic [2:0] L_SRC_U32  = 3'b000;
  localparam logic [2:0] L_SRC_I32  = 3'b001;
  localparam logic [2:0] L_SRC_FP32 = 3'b010;
  localparam logic [2:0] L_SRC_MEM  = 3'b100;
  localparam logic [2:0] L_SRC_FPU  = 3'b110;

  logic [3:0]        r_wait_mem;
  logic [3:0]        r_wait_fpu;
  logic [3:0]        r_wait_alu;
  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_rd;
  logic [2:0]        r_wb_src;
  logic              r_fmt_err;
  logic [15:0]       r_wr_count;

  logic              w_urg_mem;
  logic              w_urg_fpu;
  logic              w_urg_alu;
  logic              w_any_urg;
  logic              w_gnt_mem;
  logic              w_gnt_fpu;
  logic              w_gnt_alu;
  logic              w_we;
  logic [2:0]        w_alu_src;
  logic [2:0]        w_mux_src;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_bad_fmt;

  assign w_urg_mem = bus.mem_valid && (r_wait_mem == L_MAX_WAIT);
  assign w_urg_fpu = bus.fpu_valid && (r_wait_fpu == L_MAX_WAIT);
  assign w_urg_alu = bus.alu_valid && (r_wait_alu == L_MAX_WAIT);
  assign w_any_urg = w_urg_mem || w_urg_fpu || w_urg_alu;

  // rst_n gates the grant so the write port idles combinationally during reset.
  always_comb begin
    w_gnt_mem = 1'b0;
    w_gnt_fpu = 1'b0;
    w_gnt_alu = 1'b0;
    if (rst_n && !bus.xmm_stall) begin
      if (w_any_urg) begin
        if (w_urg_mem)      w_gnt_mem = 1'b1;
        else if (w_urg_fpu) w_gnt_fpu = 1'b1;
        else                w_gnt_alu = 1'b1;
      end else begin
        if (bus.mem_valid)      w_gnt_mem = 1'b1;
        else if (bus.fpu_valid) w_gnt_fpu = 1'b1;
        else if (bus.alu_valid) w_gnt_alu = 1'b1;
      end
    end
  end

  always_comb begin
    w_alu_src = L_SRC_U32;
    case (bus.alu_fmt)
      2'b01:   w_alu_src = L_SRC_I32;
      2'b10:   w_alu_src = L_SRC_FP32;
      default: w_alu_src = L_SRC_U32;
    endcase
  end

  always_comb begin
    w_mux_src = L_SRC_U32;
    w_waddr   = '0;
    if (w_gnt_mem) begin
      w_mux_src = L_SRC_MEM;
      w_waddr   = bus.mem_rd;
    end else if (w_gnt_fpu) begin
      w_mux_src = L_SRC_FPU;
      w_waddr   = bus.fpu_rd;
    end else if (w_gnt_alu) begin
      w_mux_src = w_alu_src;
      w_waddr   = bus.alu_rd;
    end
  end

  assign w_we      = w_gnt_mem || w_gnt_fpu || w_gnt_alu;
  assign w_bad_fmt = w_gnt_alu && (bus.alu_fmt == 2'b11);

  assign bus.mem_ready = w_gnt_mem;
  assign bus.fpu_ready = w_gnt_fpu;
  assign bus.alu_ready = w_gnt_alu;
  assign bus.xmm_we    = w_we;
  assign bus.mux_src   = w_mux_src;
  assign bus.xmm_waddr = w_waddr;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_rd     = r_wb_rd;
  assign bus.wb_src    = r_wb_src;
  assign bus.fmt_err   = r_fmt_err;
  assign bus.wr_count  = r_wr_count;

  // Grant or an idle requester clears the age; otherwise it ages, stall included.
  function automatic logic [3:0] next_wait(input logic valid, input logic gnt,
                                           input logic [3:0] cur);
    if (!valid || gnt)          return 4'd0;
    else if (cur >= L_MAX_WAIT) return L_MAX_WAIT;
    else                        return cur + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_mem <= 4'd0;
      r_wait_fpu <= 4'd0;
      r_wait_alu <= 4'd0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_src   <= 3'b000;
      r_fmt_err  <= 1'b0;
      r_wr_count <= 16'd0;
    end else begin
      r_wait_mem <= next_wait(bus.mem_valid, w_gnt_mem, r_wait_mem);
      r_wait_fpu <= next_wait(bus.fpu_valid, w_gnt_fpu, r_wait_fpu);
      r_wait_alu <= next_wait(bus.alu_valid, w_gnt_alu, r_wait_alu);
      r_wb_valid <= w_we;
      r_wb_rd    <= w_waddr;
      r_wb_src   <= w_mux_src;
      if (w_bad_fmt) r_fmt_err <= 1'b1;
      if (w_we)      r_wr_count <= r_wr_count + 16'd1;
    end
  end

endmodule
